// File: rtl/vga_timing_gen_p.sv
// Parametrised VGA raster timing generator with internal pixel-rate strobe.
// Counters are undelayed; sync/valid lag them by PIPE_DLY pixel ticks. No backpressure: free-running while en_i=1.
module vga_timing_gen_p #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 1,
    parameter int CW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic          pix_tick_o,
    output logic [CW-1:0] h_cnt_o,
    output logic [CW-1:0] v_cnt_o,
    output logic          cnt_valid_o,
    output logic          valid_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          line_start_o,
    output logic          frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIVW-1:0] div_q, div_d;
    logic [CW-1:0]   h_q, h_d, v_q, v_d;
    logic            cnt_valid_q, line_start_q, frame_start_q;
    logic            tick, h_wrap, v_wrap, hs_raw, vs_raw;
    logic [2:0]      raw, dly;

    // Gated by rst_ni so a CLK_DIV=1 strobe cannot leak out while in reset.
    assign tick   = rst_ni & en_i & (div_q == DIVW'(CLK_DIV - 1));
    assign h_wrap = tick & (h_q == CW'(H_TOTAL - 1));
    assign v_wrap = h_wrap & (v_q == CW'(V_TOTAL - 1));

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (!en_i) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (tick) begin
            div_d = '0;
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end else begin
            div_d = div_q + DIVW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            cnt_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            cnt_valid_q   <= en_i && (h_d < CW'(H_ACTIVE)) && (v_d < CW'(V_ACTIVE));
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign hs_raw = (h_q >= CW'(HS_BEG)) && (h_q < CW'(HS_END));
    assign vs_raw = (v_q >= CW'(VS_BEG)) && (v_q < CW'(VS_END));
    assign raw    = {cnt_valid_q, hs_raw, vs_raw};

    generate
        if (PIPE_DLY == 0) begin : g_nopipe
            assign dly = raw;
        end else begin : g_pipe
            // Advances only on pixel ticks so latency scales with CLK_DIV.
            logic [2:0] pipe_q [PIPE_DLY];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= '0;
                end else if (!en_i) begin
                    for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= '0;
                end else if (tick) begin
                    pipe_q[0] <= raw;
                    for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign dly = pipe_q[PIPE_DLY-1];
        end
    endgenerate

    assign pix_tick_o    = tick;
    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign cnt_valid_o   = cnt_valid_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign valid_o       = dly[2];
    assign hsync_o       = dly[1] ? HS_POL : ~HS_POL;
    assign vsync_o       = dly[0] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_gen_p.sv
// Bench for vga_timing_gen_p: four parameter sets driven by shared en/reset,
// every output compared each cycle against a raster model built from tick counts.
module tb_vga_timing_gen_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en;

    logic       a_pt, a_cv, a_vl, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_pt, b_cv, b_vl, b_hs, b_vs, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_pt, c_cv, c_vl, c_hs, c_vs, c_ls, c_fs;
    logic [3:0] c_h, c_v;
    logic       d_pt, d_cv, d_vl, d_hs, d_vs, d_ls, d_fs;
    logic [3:0] d_h, d_v;

    vga_timing_gen_p u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pix_tick_o(a_pt), .h_cnt_o(a_h), .v_cnt_o(a_v),
        .cnt_valid_o(a_cv), .valid_o(a_vl), .hsync_o(a_hs), .vsync_o(a_vs),
        .line_start_o(a_ls), .frame_start_o(a_fs));

    vga_timing_gen_p #(.PIPE_DLY(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pix_tick_o(b_pt), .h_cnt_o(b_h), .v_cnt_o(b_v),
        .cnt_valid_o(b_cv), .valid_o(b_vl), .hsync_o(b_hs), .vsync_o(b_vs),
        .line_start_o(b_ls), .frame_start_o(b_fs));

    vga_timing_gen_p #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DLY(2), .CW(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pix_tick_o(c_pt), .h_cnt_o(c_h), .v_cnt_o(c_v),
        .cnt_valid_o(c_cv), .valid_o(c_vl), .hsync_o(c_hs), .vsync_o(c_vs),
        .line_start_o(c_ls), .frame_start_o(c_fs));

    vga_timing_gen_p #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
                       .PIPE_DLY(3), .CW(4)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pix_tick_o(d_pt), .h_cnt_o(d_h), .v_cnt_o(d_v),
        .cnt_valid_o(d_cv), .valid_o(d_vl), .hsync_o(d_hs), .vsync_o(d_vs),
        .line_start_o(d_ls), .frame_start_o(d_fs));

    typedef struct {
        int cd, ha, hf, hs, hb, va, vf, vs, vb, hp, vp, pd;
    } cfg_t;

    typedef struct {
        int pt, h, v, cv, vl, hs, vs, ls, fs;
    } exp_t;

    cfg_t cfg_a = '{cd:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:0, vp:0, pd:1};
    cfg_t cfg_b = '{cd:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, hp:0, vp:0, pd:0};
    cfg_t cfg_c = '{cd:1, ha:8, hf:1, hs:2, hb:1, va:4, vf:1, vs:1, vb:1, hp:0, vp:0, pd:2};
    cfg_t cfg_d = '{cd:2, ha:8, hf:1, hs:2, hb:1, va:4, vf:1, vs:1, vb:1, hp:1, vp:1, pd:3};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Clocks elapsed since the last reset/disable with en high.
    int n_mdl = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)   n_mdl <= 0;
        else if (!en) n_mdl <= 0;
        else          n_mdl <= n_mdl + 1;
    end

    // Raster state visible during clock m after restart: position = completed ticks.
    function automatic void raw_at(input cfg_t c, input int m, output int cv, output int hs, output int vs);
        int ht, vt, t, p, h, v;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        t  = m / c.cd;
        p  = t % (ht * vt);
        h  = p % ht;
        v  = p / ht;
        cv = (m >= 1 && h < c.ha && v < c.va) ? 1 : 0;
        hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? 1 : 0;
        vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? 1 : 0;
    endfunction

    function automatic exp_t model(input cfg_t c, input int n, input bit en_b, input bit rn);
        exp_t e;
        int ht, vt, t, p, dv, dh, dvs, rh, rv;
        ht   = c.ha + c.hf + c.hs + c.hb;
        vt   = c.va + c.vf + c.vs + c.vb;
        t    = n / c.cd;
        p    = t % (ht * vt);
        e.h  = p % ht;
        e.v  = p / ht;
        e.pt = (en_b && rn && (n % c.cd == c.cd - 1)) ? 1 : 0;
        raw_at(c, n, e.cv, rh, rv);
        e.ls = (n >= c.cd && n % c.cd == 0 && e.h == 0) ? 1 : 0;
        e.fs = (e.ls == 1 && e.v == 0) ? 1 : 0;
        // Delay line holds the raw state sampled just before each of the last pd ticks.
        if (c.pd == 0) raw_at(c, n, dv, dh, dvs);
        else if (t < c.pd) begin dv = 0; dh = 0; dvs = 0; end
        else raw_at(c, (t - c.pd + 1) * c.cd - 1, dv, dh, dvs);
        e.vl = dv;
        e.hs = dh ? c.hp : 1 - c.hp;
        e.vs = dvs ? c.vp : 1 - c.vp;
        return e;
    endfunction

    task automatic check_inst(input string nm, input cfg_t c, input logic [31:0] pt, h, v,
                              cv, vl, hs, vs, ls, fs);
        exp_t e;
        e = model(c, n_mdl, en, rst_n);
        chk({nm, ".pix_tick"}, pt, e.pt);
        chk({nm, ".h_cnt"}, h, e.h);
        chk({nm, ".v_cnt"}, v, e.v);
        chk({nm, ".cnt_valid"}, cv, e.cv);
        chk({nm, ".valid"}, vl, e.vl);
        chk({nm, ".hsync"}, hs, e.hs);
        chk({nm, ".vsync"}, vs, e.vs);
        chk({nm, ".line_start"}, ls, e.ls);
        chk({nm, ".frame_start"}, fs, e.fs);
    endtask

    always @(negedge clk) begin
        check_inst("A", cfg_a, a_pt, a_h, a_v, a_cv, a_vl, a_hs, a_vs, a_ls, a_fs);
        check_inst("B", cfg_b, b_pt, b_h, b_v, b_cv, b_vl, b_hs, b_vs, b_ls, b_fs);
        check_inst("C", cfg_c, c_pt, c_h, c_v, c_cv, c_vl, c_hs, c_vs, c_ls, c_fs);
        check_inst("D", cfg_d, d_pt, d_h, d_v, d_cv, d_vl, d_hs, d_vs, d_ls, d_fs);
    end

    // Release reset with en=1: first tick is consumed on edge 4, moving h_cnt to 1.
    task automatic release_check();
        int got, pt3;
        got = -1;
        pt3 = -1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) pt3 = int'(a_pt);
            if (a_h == 10'd1 && got < 0) got = i;
        end
        chk("tick_before_edge4", pt3, 1);
        chk("first_h1_edge", got, 4);
    endtask

    initial begin
        int cnt;
        bit seen;
        rst_n = 1'b1;
        en    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_hsync_a", a_hs, 1);
        chk("rst_vsync_a", a_vs, 1);
        chk("rst_idle_hs_d", d_hs, 0);
        chk("rst_idle_vs_d", d_vs, 0);
        release_check();

        seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin @(negedge clk); seen = a_ls; end
        chk("line_start_seen", seen, 1);
        cnt = 0; seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin @(negedge clk); cnt++; seen = a_ls; end
        chk("line_len_clks", cnt, 3200);

        seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin @(negedge clk); seen = !b_hs; end
        chk("hs_fall_h", b_h, 656);
        cnt = 0;
        for (int i = 0; i < 4000 && b_hs == 1'b0; i++) begin @(negedge clk); cnt++; end
        chk("hs_low_clks", cnt, 384);

        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = c_fs; end
        chk("c_frame_seen", seen, 1);
        cnt = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); cnt++; seen = c_fs; end
        chk("c_frame_len", cnt, 84);

        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (c_h == 4'd5 && c_v == 4'd2);
        end
        chk("c_pos_5_2_seen", seen, 1);
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("gap_h", c_h, 0);
            chk("gap_v", c_v, 0);
            chk("gap_valid", c_vl, 0);
            chk("gap_vsync", c_vs, 1);
        end
        @(posedge clk);
        #1 en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (c_fs) cnt++; end
        chk("no_spurious_fs", cnt, 0);

        seen = 0;
        for (int i = 0; i < 4000 && !seen; i++) begin @(negedge clk); seen = !a_hs; end
        chk("a_hsync_low_seen", seen, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_hs_a", a_hs, 1);
        chk("async_h_a", a_h, 0);
        chk("async_ls_a", a_ls, 0);
        repeat (3) @(negedge clk);
        release_check();

        for (int it = 0; it < 30; it++) begin
            int r;
            repeat ($urandom_range(1, 900)) @(posedge clk);
            r = $urandom_range(0, 3);
            if (r == 0) begin
                #2 rst_n = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #2 rst_n = 1'b1;
            end else if (r == 1) begin
                #1 en = 1'b0;
                repeat ($urandom_range(1, 15)) @(posedge clk);
                #1 en = 1'b1;
            end
        end
        repeat (50) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen_p.md
Name: vga_timing_gen_p

Overview:
- Parametrised VGA raster timing generator; the next generation of the fixed 640x480 controller.
- Derives its own pixel-rate strobe from the system clock instead of needing a divided clock.
- Supports any resolution and either sync polarity.
- Delays sync and valid by a programmable pipeline depth so they line up with pixel data returned from block-RAM lookups addressed by h_cnt/v_cnt.

Parameters:
CLK_DIV, 4, system clocks per pixel tick (>=1; 1 = tick every cycle)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
PIPE_DLY, 1, pixel ticks of delay applied to hsync/vsync/valid (0..15)
CW, 10, width of h_cnt/v_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
en  in  1  run enable
pix_tick  out  1  one-clk strobe at pixel rate
h_cnt  out  CW  horizontal position, undelayed (address generation)
v_cnt  out  CW  vertical position, undelayed
cnt_valid  out  1  h_cnt<H_ACTIVE && v_cnt<V_ACTIVE, undelayed
valid  out  1  cnt_valid delayed PIPE_DLY ticks
hsync  out  1  delayed horizontal sync
vsync  out  1  delayed vertical sync
line_start  out  1  one-clk pulse when h_cnt wraps to 0
frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) wraps to (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must fit in CW bits.
- Reset (rst=0, async):
  - divider=0; h_cnt=0; v_cnt=0; all delay-line stages cleared.
  - pix_tick=0, cnt_valid=0, valid=0, line_start=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL (inactive levels).
- Divider:
  - counts 0..CLK_DIV-1 while en=1.
  - pix_tick=1 for the cycle in which divider==CLK_DIV-1.
  - CLK_DIV=1: pix_tick=en.
- Counters advance only on pix_tick:
  - h_cnt==H_TOTAL-1: h_cnt->0; v_cnt increments, or wraps to 0 when v_cnt==V_TOTAL-1.
  - otherwise h_cnt+1.
- line_start is registered and asserted the clk after each tick on which h_cnt wraps. frame_start is asserted on the same clk when v_cnt also wraps. Each is exactly one clk wide.
- cnt_valid is registered from the next counter values, so it changes in the same clk as h_cnt/v_cnt.
- Raw sync, computed from the counters:
  - hs_raw asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Delay line: {cnt_valid, hs_raw, vs_raw} pass through a PIPE_DLY-stage shift register advanced only on pix_tick. PIPE_DLY=0 is a combinational pass-through of the registered values.
- Output levels: hsync = HS_POL when delayed hs asserted, else ~HS_POL; vsync likewise with VS_POL.
- en=0, effective at the next clk:
  - divider, h_cnt, v_cnt forced to 0; delay line cleared.
  - outputs go to their reset values; no pulses.
  - On re-enable, the first pix_tick occurs CLK_DIV clks later and the frame restarts at (0,0).
  - No frame_start is emitted for that restart; the first frame_start is at the first natural wrap.
- Mid-frame reset: immediate return to reset state; no partial pulse is emitted.
- Latency from counter position to delayed outputs is exactly PIPE_DLY*CLK_DIV clks.

Test Plan:
1. Default params, rst held 0 then released with en=1:
   - All outputs at reset values during reset (hsync=1, vsync=1).
   - First pix_tick on clk 4 after release.
   - h_cnt reaches 1 on the clk after that first pix_tick.
2. Default params, PIPE_DLY=0, one line:
   - hsync goes low exactly when h_cnt becomes 656 and returns high when h_cnt becomes 752 (96 ticks = 384 clks).
   - Line length 3200 clks between line_start pulses.
3. Small params (H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, PIPE_DLY=2):
   - valid lags cnt_valid by 2 clks.
   - vsync low for one line starting at v_cnt=5.
   - frame_start every 12*7=84 clks.
4. HS_POL=1, VS_POL=1, small params: sync pulses positive; idle level 0 after reset.
5. Small params, deassert en at h_cnt=5, v_cnt=2 for 10 clks, then reassert:
   - Counters 0 and outputs inactive during the gap.
   - Restart from (0,0); no spurious frame_start.
6. Assert rst mid-hsync:
   - hsync immediately returns to the inactive level (asynchronous).
   - After release, timing is identical to scenario 1.
